ir_receiver: RTL and testbench

IR_RECEIVER -- requirements
Module: ir_receiver

---
 rtl/ir_receiver.sv | 175 +++++++++++++++++
 tb/tb_ir_receiver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ir_receiver.sv
// ---------------------------------------------------------------------------
// ir_receiver
//   Measures the period of an IR carrier (rising edge to rising edge) and
//   declares the carrier locked after a run of in-range periods. Loses the
//   lock after a run of out-of-range periods, or when no edge arrives for
//   TIMEOUT cycles.
//
// Ports
//   clk            in   system clock, all logic on rising edge
//   rst_n          in   asynchronous active-low reset
//   signalIn       in   raw IR detector output, asynchronous to clk
//   carrier_detect out  high while the carrier is locked
//   period_strobe  out  one-cycle pulse when a new period is available
//   period_out     out  last measured period in clk cycles (17 bits)
//   period_ok      out  period_out lies within [PERIOD_MIN, PERIOD_MAX]
// ---------------------------------------------------------------------------
module ir_receiver #(
    parameter int PERIOD_MIN = 30000,
    parameter int PERIOD_MAX = 36667,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 2,
    parameter int TIMEOUT    = 73334
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signalIn,
    output logic        carrier_detect,
    output logic        period_strobe,
    output logic [16:0] period_out,
    output logic        period_ok
);

    localparam logic [16:0] MIN_V     = 17'(PERIOD_MIN);
    localparam logic [16:0] MAX_V     = 17'(PERIOD_MAX);
    localparam logic [16:0] TIMEOUT_V = 17'(TIMEOUT);
    localparam logic [7:0]  LOCK_V    = 8'(LOCK_COUNT);
    localparam logic [7:0]  MISS_V    = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [7:0]  good_cnt, good_n;
    logic [7:0]  miss_cnt, miss_n;
    logic        sync1, sync2, sync3;
    logic        rise;
    logic        timeout;
    logic        measure;
    logic [16:0] counter;

    function automatic logic in_range(input logic [16:0] p);
        return (p >= MIN_V) && (p <= MAX_V);
    endfunction

    // Stage 1: two-flop synchroniser plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= signalIn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    // Stage 2: period counter. Loads 1 on an edge so that its value on the
    // next edge cycle equals the number of cycles between the two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (rise) begin
            counter <= 17'd1;
        end else if (counter != TIMEOUT_V) begin
            counter <= counter + 17'd1;
        end
    end

    // An edge on the saturation cycle wins over the timeout.
    assign timeout = (counter == TIMEOUT_V) && !rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
            miss_cnt <= miss_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        miss_n  = miss_cnt;
        measure = 1'b0;
        case (state)
            IDLE: begin
                // First edge only starts the measurement; nothing to report.
                if (rise) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                    miss_n  = '0;
                end
            end
            ACQUIRE: begin
                if (rise) begin
                    measure = 1'b1;
                    if (in_range(counter)) begin
                        good_n = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 >= LOCK_V) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else begin
                        good_n = '0;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    good_n  = '0;
                    miss_n  = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    measure = 1'b1;
                    if (in_range(counter)) begin
                        miss_n = '0;
                    end else if (miss_cnt + 8'd1 >= MISS_V) begin
                        state_n = ACQUIRE;
                        good_n  = '0;
                        miss_n  = '0;
                    end else begin
                        miss_n = miss_cnt + 8'd1;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    good_n  = '0;
                    miss_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                good_n  = '0;
                miss_n  = '0;
            end
        endcase
    end

    // Stage 3: registered outputs; period values hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_strobe  <= 1'b0;
            period_out     <= '0;
            period_ok      <= 1'b0;
            carrier_detect <= 1'b0;
        end else begin
            period_strobe  <= measure;
            carrier_detect <= (state == LOCKED);
            if (measure) begin
                period_out <= counter;
                period_ok  <= in_range(counter);
            end
        end
    end

endmodule

// File: tb/tb_ir_receiver.sv
// ---------------------------------------------------------------------------
// tb_ir_receiver
//   Directed bench for ir_receiver with scaled-down timing parameters
//   (nominal period 33 cycles, window 30..36, timeout 73). Each generated
//   rising edge pushes its expected period report into a queue; a monitor
//   pops and compares whenever period_strobe is seen.
// ---------------------------------------------------------------------------
module tb_ir_receiver;

    localparam int PMIN = 30;
    localparam int PMAX = 36;
    localparam int LOCKN = 4;
    localparam int MISSN = 2;
    localparam int TOUT = 73;

    logic        clk;
    logic        rst_n;
    logic        signalIn;
    logic        carrier_detect;
    logic        period_strobe;
    logic [16:0] period_out;
    logic        period_ok;

    typedef struct {
        int p;
        int ok;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    bit   armed = 0;

    ir_receiver #(
        .PERIOD_MIN(PMIN),
        .PERIOD_MAX(PMAX),
        .LOCK_COUNT(LOCKN),
        .MISS_LIMIT(MISSN),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .signalIn      (signalIn),
        .carrier_detect(carrier_detect),
        .period_strobe (period_strobe),
        .period_out    (period_out),
        .period_ok     (period_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected report.
    always @(negedge clk) begin
        if (period_strobe) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("period_out", int'(period_out), e.p);
                chk("period_ok", int'(period_ok), e.ok);
            end
        end
    end

    // Record a rising edge of signalIn and predict the report it causes.
    task automatic note_rise();
        int gap;
        exp_t e;
        gap = cyc - last_rise;
        if (armed && gap <= TOUT) begin
            e.p  = gap;
            e.ok = (gap >= PMIN && gap <= PMAX) ? 1 : 0;
            sb.push_back(e);
        end
        armed     = 1'b1;
        last_rise = cyc;
    endtask

    // One carrier period of p cycles starting with a rising edge now.
    task automatic pulse(input int p);
        @(negedge clk);
        note_rise();
        signalIn = 1'b1;
        repeat (p / 2 - 1) @(negedge clk);
        @(negedge clk);
        signalIn = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_carrier"}, int'(carrier_detect), 0);
        chk({tag, "_strobe"}, int'(period_strobe), 0);
        chk({tag, "_period"}, int'(period_out), 0);
        chk({tag, "_ok"}, int'(period_ok), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        signalIn = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Nominal carrier: lock after the fifth rising edge
        for (int i = 0; i < 4; i++) pulse(33);
        chk("lock_after4", int'(carrier_detect), 0);
        pulse(33);
        chk("lock_after5", int'(carrier_detect), 1);
        for (int i = 0; i < 3; i++) pulse(33);
        chk("lock_hold", int'(carrier_detect), 1);

        // A single long period is one miss only
        pulse(40);
        pulse(33);
        pulse(33);
        chk("single_miss_keeps_lock", int'(carrier_detect), 1);

        // Extra edge splits a period into two short ones: lock drops
        pulse(16);
        pulse(17);
        chk("first_split_miss", int'(carrier_detect), 1);
        pulse(33);
        chk("split_drops_lock", int'(carrier_detect), 0);

        // Relock needs four in-range periods from ACQUIRE
        for (int i = 0; i < 3; i++) pulse(33);
        chk("relock_after3", int'(carrier_detect), 0);
        pulse(33);
        chk("relock_after4", int'(carrier_detect), 1);

        // Edge on the exact timeout cycle is measured as TIMEOUT, out of range
        pulse(73);
        pulse(33);
        chk("edge_at_timeout_keeps_lock", int'(carrier_detect), 1);
        pulse(33);

        // Signal held low: carrier drops about 76 cycles after the last rise
        repeat (38) @(negedge clk);
        chk("timeout_before", int'(carrier_detect), 1);
        repeat (10) @(negedge clk);
        chk("timeout_after", int'(carrier_detect), 0);

        // Slow carrier: every gap exceeds the timeout, never locks, no reports
        for (int i = 0; i < 4; i++) begin
            pulse(100);
            chk("slow_no_lock", int'(carrier_detect), 0);
        end

        // Reacquire from IDLE, then reset while locked
        for (int i = 0; i < 5; i++) pulse(33);
        chk("lock_before_reset", int'(carrier_detect), 1);
        @(negedge clk);
        rst_n = 1'b0;
        armed = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_window");
        chk("no_pending_at_reset", sb.size(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) pulse(33);
        chk("post_reset_after4", int'(carrier_detect), 0);
        pulse(33);
        chk("post_reset_after5", int'(carrier_detect), 1);

        repeat (10) @(negedge clk);
        chk("reports_outstanding", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
